// File: rtl/common_pkg.sv
// Shared types for the redundant-to-binary converter: FSM states, carry and redundant word types.
// Carries are 2 bits: a DSP_BIT_LEN = WORD_LEN+1 word plus carry <= 2 never carries out more than 2.
// No timing or flow control lives here.
package common_pkg;

    localparam int REDUN_WORD_LEN    = 16;
    localparam int REDUN_DSP_BIT_LEN = REDUN_WORD_LEN + 1;

    typedef logic [REDUN_DSP_BIT_LEN-1:0] redun_word_t;
    typedef logic [1:0]                   carry_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/redun_carry_step.sv
// Adds an incoming carry to one redundant word, splitting the sum into a canonical word and a carry.
// Latency: combinational.
// Backpressure: none; it has no handshake.
module redun_carry_step
    import common_pkg::*;
#(
    parameter int WORD_LEN    = 16,
    parameter int DSP_BIT_LEN = WORD_LEN + 1
) (
    input  logic [DSP_BIT_LEN-1:0] word_i,
    input  carry_t                 carry_i,
    output logic [WORD_LEN-1:0]    sum_word_o,
    output carry_t                 carry_o
);

    localparam int SUM_W = DSP_BIT_LEN + 1;

    logic [SUM_W-1:0] sum;

    assign sum        = SUM_W'(word_i) + SUM_W'(carry_i);
    assign sum_word_o = sum[WORD_LEN-1:0];
    assign carry_o    = sum[WORD_LEN +: 2];

endmodule

// File: rtl/redun_to_binary.sv
// Resolves a redundant multi-word operand into canonical binary with a 2-bit carry-out.
// Latency: NUM_ELEMENTS+1 cycles from accept, or ceil(NUM_ELEMENTS/2)+1 with REDUN_TO_BIN_DUAL_EN.
// Backpressure: accepts only when idle; the result is held until i_rdy is seen.
module redun_to_binary
    import common_pkg::*;
#(
    parameter int NUM_ELEMENTS = 3,
    parameter int WORD_LEN     = 16,
    parameter int DSP_BIT_LEN  = WORD_LEN + 1
) (
    input  logic                                    i_clk,
    input  logic                                    i_rst_n,
    input  logic [NUM_ELEMENTS-1:0][DSP_BIT_LEN-1:0] i_dat,
    input  logic                                    i_val,
    output logic                                    o_rdy,
    output logic [NUM_ELEMENTS*WORD_LEN-1:0]         o_dat,
    output logic [1:0]                              o_carry,
    output logic                                    o_val,
    input  logic                                    i_rdy
);

    localparam int IDX_W = $clog2(NUM_ELEMENTS + 2);

    state_e                                   state_q, state_d;
    logic [NUM_ELEMENTS-1:0][DSP_BIT_LEN-1:0] dat_q, dat_d;
    logic [IDX_W-1:0]                         idx_q, idx_d;
    carry_t                                   carry_q, carry_d;
    logic [NUM_ELEMENTS*WORD_LEN-1:0]         res_q, res_d;
    logic                                     val_q, val_d;

    logic [WORD_LEN-1:0] w0;
    carry_t              c0;

    redun_carry_step #(
        .WORD_LEN    (WORD_LEN),
        .DSP_BIT_LEN (DSP_BIT_LEN)
    ) u_step0 (
        .word_i     (dat_q[idx_q]),
        .carry_i    (carry_q),
        .sum_word_o (w0),
        .carry_o    (c0)
    );

`ifdef REDUN_TO_BIN_DUAL_EN
    logic                has_pair;
    logic [IDX_W-1:0]    idx1;
    logic [WORD_LEN-1:0] w1;
    carry_t              c1;

    // An odd trailing element has no partner; the second step then sees a duplicate and is ignored.
    assign has_pair = (int'(idx_q) + 1 < NUM_ELEMENTS);
    assign idx1     = has_pair ? idx_q + IDX_W'(1) : idx_q;

    redun_carry_step #(
        .WORD_LEN    (WORD_LEN),
        .DSP_BIT_LEN (DSP_BIT_LEN)
    ) u_step1 (
        .word_i     (dat_q[idx1]),
        .carry_i    (c0),
        .sum_word_o (w1),
        .carry_o    (c1)
    );
`endif

    always_comb begin
        state_d = state_q;
        dat_d   = dat_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        res_d   = res_q;
        val_d   = val_q;
        case (state_q)
            IDLE: begin
                if (i_val) begin
                    dat_d   = i_dat;
                    carry_d = '0;
                    idx_d   = '0;
                    state_d = CONV;
                end
            end
            CONV: begin
                res_d[int'(idx_q)*WORD_LEN +: WORD_LEN] = w0;
`ifdef REDUN_TO_BIN_DUAL_EN
                if (has_pair) begin
                    res_d[int'(idx1)*WORD_LEN +: WORD_LEN] = w1;
                    carry_d = c1;
                end else begin
                    carry_d = c0;
                end
                if (int'(idx_q) + 2 >= NUM_ELEMENTS) begin
                    state_d = DONE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + IDX_W'(2);
                end
`else
                carry_d = c0;
                if (int'(idx_q) == NUM_ELEMENTS - 1) begin
                    state_d = DONE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
`endif
            end
            DONE: begin
                // o_val rises one cycle after entering DONE, giving the registered result a settle cycle.
                val_d = 1'b1;
                if (val_q && i_rdy) begin
                    val_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            dat_q   <= '0;
            idx_q   <= '0;
            carry_q <= '0;
            res_q   <= '0;
            val_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dat_q   <= dat_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            res_q   <= res_d;
            val_q   <= val_d;
        end
    end

    assign o_rdy   = (state_q == IDLE);
    assign o_dat   = res_q;
    assign o_carry = carry_q;
    assign o_val   = val_q;

endmodule

// File: tb/tb_redun_to_binary.sv
// Bench for redun_to_binary at NUM_ELEMENTS=3, WORD_LEN=16; directed corners plus random operands
// checked against the arithmetic value of the redundant operand.
module tb_redun_to_binary;
    import common_pkg::redun_word_t;

    localparam int NE  = 3;
    localparam int WL  = 16;
    localparam int DSP = WL + 1;
`ifdef REDUN_TO_BIN_DUAL_EN
    localparam int EXP_LAT = (NE + 1) / 2 + 1;
`else
    localparam int EXP_LAT = NE + 1;
`endif

    typedef redun_word_t [NE-1:0] op_t;

    logic            i_clk = 1'b0;
    logic            i_rst_n = 1'b0;
    op_t             i_dat = '0;
    logic            i_val = 1'b0;
    logic            o_rdy;
    logic [NE*WL-1:0] o_dat;
    logic [1:0]      o_carry;
    logic            o_val;
    logic            i_rdy = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 i_clk = ~i_clk;

    redun_to_binary #(
        .NUM_ELEMENTS (NE),
        .WORD_LEN     (WL),
        .DSP_BIT_LEN  (DSP)
    ) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_dat   (i_dat),
        .i_val   (i_val),
        .o_rdy   (o_rdy),
        .o_dat   (o_dat),
        .o_carry (o_carry),
        .o_val   (o_val),
        .i_rdy   (i_rdy)
    );

    // Numeric value of the redundant operand: sum of word k weighted by 2^(k*WL).
    function automatic logic [63:0] redun_value(input op_t op);
        logic [63:0] v;
        v = '0;
        for (int k = 0; k < NE; k++) v = v + (64'(op[k]) << (k * WL));
        return v;
    endfunction

    // Drives one operand, measures latency, captures the result, then completes the handshake.
    task automatic run_op(input op_t op, input int rdy_delay, output int lat,
                          output logic [NE*WL-1:0] dat, output logic [1:0] cry);
        int w;
        w = 0;
        while (!o_rdy && w < 50) begin
            @(posedge i_clk); #1;
            w++;
        end
        lat   = -1;
        i_dat = op;
        i_val = 1'b1;
        @(posedge i_clk); #1;
        i_val = 1'b0;
        i_dat = '0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge i_clk); #1;
            if (o_val) begin
                lat = c;
                break;
            end
        end
        dat = o_dat;
        cry = o_carry;
        if (lat > 0) begin
            repeat (rdy_delay) begin
                @(posedge i_clk); #1;
            end
            i_rdy = 1'b1;
            @(posedge i_clk); #1;
            i_rdy = 1'b0;
        end
    endtask

    task automatic test_reset;
        i_rst_n = 1'b0;
        #12;
        n_tests++; if (o_val !== 1'b0) begin n_fail++; $display("FAIL reset_o_val got %0b want 0", o_val); end
        n_tests++; if (o_dat !== '0) begin n_fail++; $display("FAIL reset_o_dat got %h want 0", o_dat); end
        n_tests++; if (o_carry !== 2'd0) begin n_fail++; $display("FAIL reset_o_carry got %0d want 0", o_carry); end
        n_tests++; if (o_rdy !== 1'b1) begin n_fail++; $display("FAIL reset_o_rdy got %0b want 1", o_rdy); end
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        @(posedge i_clk); #1;
    endtask

    task automatic test_directed;
        op_t              ops [3];
        logic [NE*WL-1:0] exp_dat [3];
        logic [1:0]       exp_cry [3];
        int               lat;
        logic [NE*WL-1:0] dat;
        logic [1:0]       cry;
        ops[0] = {17'h0FFFF, 17'h00001, 17'h00002}; exp_dat[0] = 48'hFFFF00010002; exp_cry[0] = 2'd0;
        ops[1] = {17'h1FFFF, 17'h1FFFF, 17'h1FFFF}; exp_dat[1] = 48'h00010000FFFF; exp_cry[1] = 2'd2;
        ops[2] = {17'h0FFFF, 17'h0FFFF, 17'h10000}; exp_dat[2] = 48'h000000000000; exp_cry[2] = 2'd1;
        for (int i = 0; i < 3; i++) begin
            run_op(ops[i], i, lat, dat, cry);
            n_tests++; if (lat != EXP_LAT) begin n_fail++; $display("FAIL directed%0d_latency got %0d want %0d", i, lat, EXP_LAT); end
            n_tests++; if (dat !== exp_dat[i]) begin n_fail++; $display("FAIL directed%0d_dat got %h want %h", i, dat, exp_dat[i]); end
            n_tests++; if (cry !== exp_cry[i]) begin n_fail++; $display("FAIL directed%0d_carry got %0d want %0d", i, cry, exp_cry[i]); end
            n_tests++; if (o_val !== 1'b0 || o_rdy !== 1'b1) begin n_fail++; $display("FAIL directed%0d_release val=%0b rdy=%0b want 0/1", i, o_val, o_rdy); end
        end
    endtask

    task automatic test_canonical;
        op_t              op;
        int               lat;
        logic [NE*WL-1:0] dat, exp_dat;
        logic [1:0]       cry;
        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < NE; k++) op[k] = 17'($urandom_range(0, 16'hFFFF));
            exp_dat = '0;
            for (int k = 0; k < NE; k++) exp_dat[k*WL +: WL] = op[k][WL-1:0];
            run_op(op, 0, lat, dat, cry);
            n_tests++; if (dat !== exp_dat || cry !== 2'd0) begin
                n_fail++; $display("FAIL canonical%0d got %h/%0d want %h/0", i, dat, cry, exp_dat);
            end
        end
    endtask

    task automatic test_backpressure;
        op_t              a, b;
        logic [63:0]      va, vb;
        int               lat;
        a  = {17'h1ABCD, 17'h0F00F, 17'h1FFFF};
        b  = {17'h00123, 17'h1FFFF, 17'h10001};
        va = redun_value(a);
        vb = redun_value(b);
        i_dat = a;
        i_val = 1'b1;
        @(posedge i_clk); #1;
        i_dat = b;
        lat = -1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge i_clk); #1;
            if (o_val) begin lat = c; break; end
        end
        n_tests++; if (lat != EXP_LAT) begin n_fail++; $display("FAIL bp_latency got %0d want %0d", lat, EXP_LAT); end
        for (int c = 0; c < 5; c++) begin
            @(posedge i_clk); #1;
            n_tests++; if (o_val !== 1'b1 || o_rdy !== 1'b0 || o_dat !== va[47:0] || o_carry !== va[49:48]) begin
                n_fail++; $display("FAIL bp_hold%0d got val=%0b rdy=%0b dat=%h c=%0d want 1/0/%h/%0d",
                                   c, o_val, o_rdy, o_dat, o_carry, va[47:0], va[49:48]);
            end
        end
        i_rdy = 1'b1;
        @(posedge i_clk); #1;
        i_rdy = 1'b0;
        n_tests++; if (o_val !== 1'b0 || o_rdy !== 1'b1) begin
            n_fail++; $display("FAIL bp_release got val=%0b rdy=%0b want 0/1", o_val, o_rdy);
        end
        @(posedge i_clk); #1;
        i_val = 1'b0;
        i_dat = '0;
        lat = -1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge i_clk); #1;
            if (o_val) begin lat = c; break; end
        end
        n_tests++; if (lat != EXP_LAT || o_dat !== vb[47:0] || o_carry !== vb[49:48]) begin
            n_fail++; $display("FAIL bp_next got lat=%0d dat=%h c=%0d want %0d/%h/%0d",
                               lat, o_dat, o_carry, EXP_LAT, vb[47:0], vb[49:48]);
        end
        i_rdy = 1'b1;
        @(posedge i_clk); #1;
        i_rdy = 1'b0;
    endtask

    task automatic test_reset_mid_conv;
        op_t              op;
        logic [63:0]      v;
        int               lat;
        logic [NE*WL-1:0] dat;
        logic [1:0]       cry;
        bit               seen;
        op    = {17'h1FFFF, 17'h1FFFF, 17'h1FFFF};
        i_dat = op;
        i_val = 1'b1;
        @(posedge i_clk); #1;
        i_val = 1'b0;
        @(posedge i_clk); #1;
        @(posedge i_clk); #1;
        i_rst_n = 1'b0;
        #1;
        n_tests++; if (o_val !== 1'b0 || o_dat !== '0 || o_carry !== 2'd0 || o_rdy !== 1'b1) begin
            n_fail++; $display("FAIL midreset_clear got val=%0b dat=%h c=%0d rdy=%0b want 0/0/0/1", o_val, o_dat, o_carry, o_rdy);
        end
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        seen = 1'b0;
        repeat (8) begin
            @(posedge i_clk); #1;
            if (o_val) seen = 1'b1;
        end
        n_tests++; if (seen) begin n_fail++; $display("FAIL midreset_no_result got o_val=1 want 0"); end
        op = {17'h0FFFF, 17'h0FFFF, 17'h10000};
        v  = redun_value(op);
        run_op(op, 1, lat, dat, cry);
        n_tests++; if (lat != EXP_LAT || dat !== v[47:0] || cry !== v[49:48]) begin
            n_fail++; $display("FAIL midreset_fresh got lat=%0d dat=%h c=%0d want %0d/%h/%0d",
                               lat, dat, cry, EXP_LAT, v[47:0], v[49:48]);
        end
    endtask

    task automatic test_random;
        op_t              op;
        logic [63:0]      v;
        int               lat;
        logic [NE*WL-1:0] dat;
        logic [1:0]       cry;
        for (int i = 0; i < 1000; i++) begin
            for (int k = 0; k < NE; k++) begin
                case ($urandom_range(0, 3))
                    0:       op[k] = 17'h1FFFF;
                    1:       op[k] = 17'h0FFFF;
                    default: op[k] = 17'($urandom_range(0, 17'h1FFFF));
                endcase
            end
            v = redun_value(op);
            run_op(op, int'($urandom_range(0, 3)), lat, dat, cry);
            n_tests++; if (lat != EXP_LAT || dat !== v[47:0] || cry !== v[49:48]) begin
                n_fail++; $display("FAIL random%0d op=%h got lat=%0d dat=%h c=%0d want %0d/%h/%0d",
                                   i, op, lat, dat, cry, EXP_LAT, v[47:0], v[49:48]);
            end
        end
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_canonical();
        test_backpressure();
        test_reset_mid_conv();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/redun_to_binary.md
REDUN_TO_BINARY -- requirements
Module: redun_to_binary

Interface
REQ-001 Parameter NUM_ELEMENTS, default 3: number of redundant input words.
REQ-002 Parameter WORD_LEN, default 16: canonical bits per output word.
REQ-003 Parameter DSP_BIT_LEN, default WORD_LEN+1: bits per redundant input word.
REQ-004 Port i_clk, input, 1: single clock; all state on rising edge.
REQ-005 Port i_rst_n, input, 1: reset, asynchronous, active-low.
REQ-006 Port i_dat, input, NUM_ELEMENTS x DSP_BIT_LEN: redundant operand; value = sum of i_dat[k] << (k*WORD_LEN).
REQ-007 Port i_val, input, 1: i_dat valid.
REQ-008 Port o_rdy, output, 1: block can accept an operand.
REQ-009 Port o_dat, output, NUM_ELEMENTS*WORD_LEN: canonical binary result.
REQ-010 Port o_carry, output, 2: carry out of the top word.
REQ-011 Port o_val, output, 1: o_dat/o_carry valid.
REQ-012 Port i_rdy, input, 1: downstream accepts the result.

Function
REQ-013 FSM states IDLE, CONV, DONE; reset state IDLE.
REQ-014 o_rdy high only in IDLE; transfer when i_val && o_rdy; i_dat captured into an internal register on transfer; IDLE->CONV.
REQ-015 CONV processes one element per cycle, index k = 0 to NUM_ELEMENTS-1: sum = word[k] + carry; result word k = sum[WORD_LEN-1:0]; carry = sum >> WORD_LEN.
REQ-016 Carry register is 2 bits wide, cleared on capture; the maximum carry value is 2, so it never overflows.
REQ-017 After element NUM_ELEMENTS-1, CONV->DONE; o_val asserts NUM_ELEMENTS+1 cycles after the accepting edge.
REQ-018 DONE: o_val high; o_dat and o_carry stable while i_rdy is low; o_val && i_rdy -> IDLE on the next edge.
REQ-019 i_val while not in IDLE is ignored; no operand lost or merged.
REQ-020 Input with all words < 2^WORD_LEN yields o_dat equal to the concatenated low bits and o_carry = 0.
REQ-021 Result identity: o_carry*2^(NUM_ELEMENTS*WORD_LEN) + o_dat == redundant input value, for all inputs.

Reset
REQ-022 i_rst_n low asynchronously forces state IDLE, o_val=0, o_dat=0, o_carry=0, carry=0, index=0; o_rdy=1 while in IDLE.
REQ-023 Reset during CONV or DONE aborts the operation; no result is emitted after release.

Configuration
REQ-024 Macro REDUN_TO_BIN_DUAL_EN defined: CONV processes elements 2k and 2k+1 per cycle with chained carry; latency becomes ceil(NUM_ELEMENTS/2)+1 cycles; an odd final element is processed alone.
REQ-025 Macro undefined: one element per cycle as in REQ-015/017; results are identical in both modes.

Structure
REQ-026 Shared package common_pkg holds the FSM state enum and a redun-word typedef parameterised by DSP_BIT_LEN; the single-element add (sum/word/carry split) is the natural sub-module redun_carry_step, instantiated once, or twice with REDUN_TO_BIN_DUAL_EN.

Verification (NUM_ELEMENTS=3, WORD_LEN=16)
REQ-027 Input {0x00002,0x00001,0x0FFFF} (k=0..2) -> o_dat=0xFFFF00010002, o_carry=0, o_val 4 cycles after accept (3 with DUAL_EN).
REQ-028 Input {0x1FFFF,0x1FFFF,0x1FFFF} -> o_dat=0x00010000FFFF, o_carry=2.
REQ-029 Input {0x10000,0x0FFFF,0x0FFFF} -> o_dat=0x000000000000, o_carry=1 (full ripple).
REQ-030 Hold i_rdy low 5 cycles in DONE with i_val high -> o_dat stable, o_rdy low, no second capture; i_rdy high -> IDLE, next operand accepted.
REQ-031 Drop i_rst_n mid-CONV -> o_val=0, o_dat=0 immediately; after release a fresh operand converts correctly.
REQ-032 1000 random operands against a reference model built on REQ-021, run with and without REDUN_TO_BIN_DUAL_EN -> zero mismatches.
